// File: rtl/aes_host_loader.sv
// aes_host_loader: host-side staging block for the AES core.
// Gathers a 128-bit plaintext and key from 32-bit host writes, runs the
// aes_start/aes_ready/aes_valid handshake with the round controller and
// buffers the ciphertext for 32-bit host reads.
//
// Optional feature macro: AES_LOADER_TIMEOUT_EN (adds a 5-bit watchdog and
// the sticky timeout output).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data host write (0-3 plaintext, 4-7 key, word 0/4 = MSW)
//   go, clr               start request, clear of mask/done/timeout
//   rd_addr, rd_data      registered result read (word 0 = MSW)
//   plaintext, key        staged operands to the datapath
//   aes_start/aes_ready/aes_valid/ciphertext_in  round controller handshake
//   busy, done, go_err    status (timeout with AES_LOADER_TIMEOUT_EN)
module aes_host_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         go,
  input  logic         clr,
  input  logic [1:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic [127:0] plaintext,
  output logic [127:0] key,
  output logic         aes_start,
  input  logic         aes_ready,
  input  logic         aes_valid,
  input  logic [127:0] ciphertext_in,
  output logic         busy,
  output logic         done,
  output logic         go_err
`ifdef AES_LOADER_TIMEOUT_EN
  ,
  output logic         timeout
`endif
);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e         r_state, w_state_next;
  logic [7:0]     r_mask, w_mask_next;
  logic [127:0]   r_pt, r_key, r_result;
  logic [31:0]    r_rd_data;
  logic           r_done, w_done_next;
  logic           r_go_err, w_go_err_next;
  logic           w_capture;
  logic           w_host_ok;
  logic           w_wr_ok;
  logic           w_busy;
  logic [6:0]     w_wr_lsb;
  logic [6:0]     w_rd_lsb;
`ifdef AES_LOADER_TIMEOUT_EN
  logic [4:0]     r_wdog, w_wdog_next;
  logic           r_timeout, w_timeout_next;
`endif

  assign w_host_ok = (r_state == StIdle) || (r_state == StDone);
  assign w_wr_ok   = w_host_ok && wr_en;
  assign w_busy    = (r_state == StStart) || (r_state == StRun);
  // Word 0 sits in the top 32 bits, so the bit offset is (3 - index) * 32.
  assign w_wr_lsb  = {~wr_addr[1:0], 5'd0};
  assign w_rd_lsb  = {~rd_addr, 5'd0};

  always_comb begin
    w_state_next  = r_state;
    w_mask_next   = r_mask;
    w_done_next   = r_done;
    w_go_err_next = 1'b0;
    w_capture     = 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
    w_timeout_next = r_timeout;
    // Zero outside START/RUN, so it is clear on every entry to START.
    w_wdog_next    = w_busy ? r_wdog + 5'd1 : 5'd0;
`endif

    if (w_wr_ok) begin
      w_mask_next = r_mask | (8'd1 << wr_addr);
    end

    unique case (r_state)
      StIdle, StDone: begin
        if (clr) begin
          // clr beats a simultaneous go; the go is dropped silently.
          w_state_next = StIdle;
          w_mask_next  = 8'h00;
          w_done_next  = 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
          w_timeout_next = 1'b0;
`endif
        end else if (go) begin
          // Judged on the registered mask, i.e. before any same-cycle write.
          if (r_mask == 8'hFF) begin
            w_state_next = StStart;
            w_done_next  = 1'b0;
          end else begin
            w_go_err_next = 1'b1;
          end
        end
      end
      StStart: begin
        if (!aes_ready) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (aes_valid) begin
          w_capture    = 1'b1;
          w_done_next  = 1'b1;
          w_state_next = StDone;
        end
      end
      default: w_state_next = StIdle;
    endcase

`ifdef AES_LOADER_TIMEOUT_EN
    // Counter would reach 31 on this edge with no result captured.
    if (w_busy && !w_capture && (r_wdog == 5'd30)) begin
      w_state_next   = StIdle;
      w_timeout_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_mask    <= 8'h00;
      r_pt      <= '0;
      r_key     <= '0;
      r_result  <= '0;
      r_rd_data <= '0;
      r_done    <= 1'b0;
      r_go_err  <= 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
      r_wdog    <= 5'd0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_mask    <= w_mask_next;
      r_done    <= w_done_next;
      r_go_err  <= w_go_err_next;
      r_rd_data <= r_result[w_rd_lsb +: 32];
      if (w_wr_ok) begin
        if (wr_addr[2]) begin
          r_key[w_wr_lsb +: 32] <= wr_data;
        end else begin
          r_pt[w_wr_lsb +: 32] <= wr_data;
        end
      end
      if (w_capture) begin
        r_result <= ciphertext_in;
      end
`ifdef AES_LOADER_TIMEOUT_EN
      r_wdog    <= w_wdog_next;
      r_timeout <= w_timeout_next;
`endif
    end
  end

  assign rd_data   = r_rd_data;
  assign plaintext = r_pt;
  assign key       = r_key;
  assign aes_start = (r_state == StStart);
  assign busy      = w_busy;
  assign done      = r_done;
  assign go_err    = r_go_err;
`ifdef AES_LOADER_TIMEOUT_EN
  assign timeout   = r_timeout;
`endif

endmodule

// File: tb/tb_aes_host_loader.sv
// Self-checking bench for aes_host_loader. A behavioural model (word arrays,
// a per-address loaded flag and a busy flag) predicts every observed value;
// the round controller is emulated by a task driving aes_ready/aes_valid.
module tb_aes_host_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         go;
  logic         clr;
  logic [1:0]   rd_addr;
  logic [31:0]  rd_data;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         aes_start;
  logic         aes_ready;
  logic         aes_valid;
  logic [127:0] ciphertext_in;
  logic         busy;
  logic         done;
  logic         go_err;
`ifdef AES_LOADER_TIMEOUT_EN
  logic         timeout;
`endif

  aes_host_loader u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .go            (go),
    .clr           (clr),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .plaintext     (plaintext),
    .key           (key),
    .aes_start     (aes_start),
    .aes_ready     (aes_ready),
    .aes_valid     (aes_valid),
    .ciphertext_in (ciphertext_in),
    .busy          (busy),
    .done          (done),
    .go_err        (go_err)
`ifdef AES_LOADER_TIMEOUT_EN
    ,
    .timeout       (timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0]  m_pt[4];
  logic [31:0]  m_key[4];
  bit           m_loaded[8];
  logic [127:0] m_result;
  bit           m_done;
  bit           m_busy;

  function automatic logic [127:0] m_pt_vec();
    return {m_pt[0], m_pt[1], m_pt[2], m_pt[3]};
  endfunction

  function automatic logic [127:0] m_key_vec();
    return {m_key[0], m_key[1], m_key[2], m_key[3]};
  endfunction

  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < 8; i++) f &= m_loaded[i];
    return f;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_pt[i]  = '0;
      m_key[i] = '0;
    end
    for (int i = 0; i < 8; i++) m_loaded[i] = 1'b0;
    m_result = '0;
    m_done   = 1'b0;
    m_busy   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_write(input logic [2:0] a, input logic [31:0] d);
    if (!m_busy) begin
      if (a < 3'd4) m_pt[a[1:0]] = d;
      else m_key[a[1:0]] = d;
      m_loaded[a] = 1'b1;
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    m_write(a, d);
    check("wr_plaintext", plaintext, m_pt_vec());
    check("wr_key", key, m_key_vec());
  endtask

  task automatic do_go();
    bit ok;
    ok = m_full() && !m_busy;
    go = 1'b1;
    tick();
    go = 1'b0;
    if (ok) begin
      m_busy = 1'b1;
      m_done = 1'b0;
    end
    check("go_err", 128'(go_err), 128'(!ok));
    check("go_busy", 128'(busy), 128'(ok));
    check("go_start", 128'(aes_start), 128'(ok));
    check("go_done", 128'(done), 128'(m_done));
  endtask

  // Emulated round controller: drops ready, runs 'delay' cycles, pulses valid.
  task automatic run_ctrl(input logic [127:0] ct, input int delay, input bit poke);
    check("ctrl_start_hi", 128'(aes_start), 128'(1'b1));
    aes_ready = 1'b0;
    tick();
    check("ctrl_start_fall", 128'(aes_start), 128'(1'b0));
    check("ctrl_busy_run", 128'(busy), 128'(1'b1));
    if (poke) begin
      // Write and go during a run are both ignored.
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFF_FFFF; go = 1'b1;
      tick();
      wr_en = 1'b0; go = 1'b0;
      m_write(3'd0, 32'hFFFF_FFFF);
      check("run_wr_frozen", plaintext, m_pt_vec());
      check("run_go_noerr", 128'(go_err), 128'(1'b0));
    end
    repeat (delay) tick();
    check("run_not_done", 128'(done), 128'(1'b0));
    ciphertext_in = ct; aes_valid = 1'b1;
    tick();
    aes_valid = 1'b0; aes_ready = 1'b1;
    m_result = ct; m_done = 1'b1; m_busy = 1'b0;
    check("valid_done", 128'(done), 128'(1'b1));
    check("valid_busy", 128'(busy), 128'(1'b0));
  endtask

  task automatic read_check();
    for (int k = 0; k < 4; k++) begin
      rd_addr = 2'(k);
      tick();
      check("rd_word", 128'(rd_data), 128'(m_result[(3 - k) * 32 +: 32]));
    end
  endtask

  logic [31:0] known_pt[4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  logic [31:0] known_ct[4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};

  initial begin
    logic [127:0] ct;
    bit           ok;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0; clr = 1'b0;
    rd_addr = '0; aes_ready = 1'b1; aes_valid = 1'b0; ciphertext_in = '0;
    m_reset();
    #12;
    check("rst_rd_data", 128'(rd_data), 128'(0));
    check("rst_plaintext", plaintext, 128'(0));
    check("rst_key", key, 128'(0));
    check("rst_status", 128'({aes_start, busy, done, go_err}), 128'(0));
    rst_n = 1'b1;
    tick();

    // Incomplete load: addresses 0-6 only.
    for (int a = 0; a < 7; a++) host_write(3'(a), $urandom);
    do_go();
    tick();
    check("go_err_one_cycle", 128'(go_err), 128'(1'b0));
    check("incomplete_idle", 128'({busy, aes_start}), 128'(0));

    // Same-cycle write of the last word and go: rejected, write commits.
    ok = m_full();
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = $urandom; go = 1'b1;
    tick();
    wr_en = 1'b0; go = 1'b0;
    m_write(3'd7, wr_data);
    check("same_cyc_go_err", 128'(go_err), 128'(!ok));
    check("same_cyc_key", key, m_key_vec());
    do_go();
    run_ctrl({$urandom, $urandom, $urandom, $urandom}, 3, 1'b1);
    read_check();
    host_write(3'd0, 32'hFFFF_FFFF);

    // Known-answer run: FIPS-197 vector.
    for (int i = 0; i < 4; i++) begin
      host_write(3'(i), known_pt[i]);
      host_write(3'(i + 4), {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)});
    end
    do_go();
    run_ctrl({known_ct[0], known_ct[1], known_ct[2], known_ct[3]}, 10, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rd_addr = 2'(k);
      tick();
      check("kat_rd", 128'(rd_data), 128'(known_ct[k]));
    end

    // Randomized re-encryptions under the retained key.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 1) host_write(3'(i), $urandom);
      end
      do_go();
      ct = {$urandom, $urandom, $urandom, $urandom};
      run_ctrl(ct, int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)));
      read_check();
    end

    // aes_valid outside RUN must not touch the result.
    ciphertext_in = ~m_result; aes_valid = 1'b1;
    tick();
    aes_valid = 1'b0;
    check("valid_in_done", 128'(done), 128'(1'b1));
    read_check();

    // clr together with go: clr wins, no go_err.
    clr = 1'b1; go = 1'b1;
    tick();
    clr = 1'b0; go = 1'b0;
    for (int i = 0; i < 8; i++) m_loaded[i] = 1'b0;
    m_done = 1'b0;
    check("clr_go_noerr", 128'(go_err), 128'(1'b0));
    check("clr_done", 128'(done), 128'(1'b0));
    check("clr_busy", 128'(busy), 128'(1'b0));
    do_go();

    // Reset two cycles after aes_start falls.
    for (int a = 0; a < 8; a++) host_write(3'(a), $urandom);
    do_go();
    aes_ready = 1'b0;
    tick();
    check("mid_start_fall", 128'(aes_start), 128'(1'b0));
    tick();
    tick();
    rst_n = 1'b0; aes_ready = 1'b1;
    m_reset();
    #1;
    check("midrst_plaintext", plaintext, 128'(0));
    check("midrst_key", key, 128'(0));
    check("midrst_rd", 128'(rd_data), 128'(0));
    check("midrst_status", 128'({aes_start, busy, done, go_err}), 128'(0));
    #3;
    rst_n = 1'b1;
    tick();
    do_go();

`ifdef AES_LOADER_TIMEOUT_EN
    check("rst_timeout", 128'(timeout), 128'(0));
    for (int a = 0; a < 8; a++) host_write(3'(a), $urandom);
    aes_ready = 1'b1;
    do_go();
    repeat (30) tick();
    check("wdog_31_busy", 128'(busy), 128'(1'b1));
    check("wdog_31_tmo", 128'(timeout), 128'(1'b0));
    tick();
    m_busy = 1'b0;
    check("wdog_32_tmo", 128'(timeout), 128'(1'b1));
    check("wdog_32_busy", 128'(busy), 128'(1'b0));
    check("wdog_32_start", 128'(aes_start), 128'(1'b0));
    check("wdog_done_kept", 128'(done), 128'(m_done));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_timeout", 128'(timeout), 128'(1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
